factorial_ctrl: RTL and testbench
=================================

FACTORIAL_CTRL -- requirements
Module: factorial_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  request a computation, sampled only in IDLE.
REQ-004 SHALL have ports: abort  in  1  cancel an operation in progress.
REQ-005 SHALL have ports: cnt_le1  in  1  datapath status, 1 when rda <= 1.
REQ-006 SHALL have ports: alu_ovf  in  1  datapath status, 1 when the 8-bit product overflows.
REQ-007 SHALL have ports: we, rea, reb  out  1 each  register-file write and read enables.
REQ-008 SHALL have ports: wa, raa, rab  out  2 each  register-file write and read addresses.
REQ-009 SHALL have ports: sel_in  out  2  data_in mux select: 00 = external n, 01 = constant 1, 10 = ALU result.
REQ-010 SHALL have ports: alu_op  out  1  ALU operation: 0 = MUL (rda*rdb), 1 = SUB (rda-rdb).
REQ-011 SHALL have ports: busy, done, err  out  1 each  status outputs.
REQ-012 SHALL use one clock (clk); reset rst_n SHALL be asynchronous and active-low.

Function
REQ-013 SHALL map registers as: R0 = count (CNT), R1 = accumulator (ACC), R2 = constant 1 (ONE); R3 is unused.
REQ-014 SHALL implement a Moore FSM whose outputs depend only on the current state; any output not listed for a state SHALL be 0.
REQ-015 IDLE: all outputs 0; start=1 -> INIT_N.
REQ-016 INIT_N: we=1, wa=R0, sel_in=00; -> INIT_ONE.
REQ-017 INIT_ONE: we=1, wa=R2, sel_in=01; -> INIT_ACC.
REQ-018 INIT_ACC: we=1, wa=R1, sel_in=01; -> CHECK.
REQ-019 CHECK: rea=1, raa=R0; cnt_le1=1 -> DONE, else -> MUL.
REQ-020 MUL: rea=1, raa=R1, reb=1, rab=R0, alu_op=0, sel_in=10, wa=R1; we=1 only when alu_ovf=0 (the only Mealy term); alu_ovf=1 -> ERR, else -> DEC.
REQ-021 DEC: rea=1, raa=R0, reb=1, rab=R2, alu_op=1, sel_in=10, we=1, wa=R0; -> CHECK.
REQ-022 DONE: done=1, rea=1, raa=R1 (result on rda); -> IDLE.
REQ-023 ERR: err=1; -> IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE; done and err SHALL be single-cycle pulses.
REQ-025 Latency: with start sampled at edge k, done SHALL be high in the cycle after edge k+4+3*max(n-1,0); for n=5 this is edge k+16.
REQ-026 start while busy SHALL be ignored and not queued.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE at the next edge; during that cycle we SHALL be 0; abort takes priority over all transitions, and done/err SHALL NOT pulse.
REQ-028 abort and start asserted together in IDLE: start SHALL win.

Reset
REQ-029 rst_n=0 SHALL force IDLE immediately regardless of clk, with all outputs 0 (we=0, busy=0, done=0, err=0).
REQ-030 Reset mid-operation SHALL leave register-file contents undefined; the next start SHALL reinitialise R0-R2.

Structure
REQ-031 A shared package factorial_pkg SHALL hold: the state encoding, REG_CNT/REG_ACC/REG_ONE addresses, the SEL_EXT/SEL_ONE/SEL_ALU codes, and the ALU_MUL/ALU_SUB codes.
REQ-032 The block SHALL be a single FSM module with no sub-module; a registered state plus a combinational decode is sufficient.

Verification
REQ-033 n=5, start pulse: writes 5,1,1 during init; ACC sequence 5,20,60,120; done at edge k+16; rda=120 while done is high.
REQ-034 n=0 and n=1: CHECK goes directly to DONE with no MUL; done at edge k+4; ACC=1.
REQ-035 n=6 with the datapath model: ACC goes 6,30,120; the 120*3 step sets alu_ovf; we=0 in that MUL cycle; err pulses once; ACC stays 120.
REQ-036 abort asserted in the second MUL cycle of n=5: we=0 in that cycle; IDLE at the next edge; done and err never pulse.
REQ-037 start re-pulsed while busy: no restart, the original result completes; rst_n dropped mid-DEC: outputs go to 0 asynchronously and busy=0 immediately.

Source files
------------

// File: rtl/factorial_pkg.sv
// Shared encodings for the factorial controller: FSM states, register-file
// addresses, data_in mux selects and ALU operation codes.
package factorial_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_INIT_N   = 4'd1,
        S_INIT_ONE = 4'd2,
        S_INIT_ACC = 4'd3,
        S_CHECK    = 4'd4,
        S_MUL      = 4'd5,
        S_DEC      = 4'd6,
        S_DONE     = 4'd7,
        S_ERR      = 4'd8
    } state_t;

    localparam logic [1:0] REG_CNT = 2'd0;
    localparam logic [1:0] REG_ACC = 2'd1;
    localparam logic [1:0] REG_ONE = 2'd2;

    localparam logic [1:0] SEL_EXT = 2'b00;
    localparam logic [1:0] SEL_ONE = 2'b01;
    localparam logic [1:0] SEL_ALU = 2'b10;

    localparam logic ALU_MUL = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/factorial_ctrl.sv
// Control FSM for an iterative 8-bit factorial datapath: initialises CNT/ACC/ONE,
// then loops MUL/DEC until CNT <= 1, flagging overflow as an error.
module factorial_ctrl
    import factorial_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       cnt_le1,
    input  logic       alu_ovf,
    output logic       we,
    output logic       rea,
    output logic       reb,
    output logic [1:0] wa,
    output logic [1:0] raa,
    output logic [1:0] rab,
    output logic [1:0] sel_in,
    output logic       alu_op,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t state_reg;
    state_t state_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        we         = 1'b0;
        rea        = 1'b0;
        reb        = 1'b0;
        wa         = REG_CNT;
        raa        = REG_CNT;
        rab        = REG_CNT;
        sel_in     = SEL_EXT;
        alu_op     = ALU_MUL;
        done       = 1'b0;
        err        = 1'b0;
        busy       = (state_reg != S_IDLE);

        case (state_reg)
            S_IDLE: begin
                if (start) state_next = S_INIT_N;
            end
            S_INIT_N: begin
                we         = 1'b1;
                wa         = REG_CNT;
                sel_in     = SEL_EXT;
                state_next = S_INIT_ONE;
            end
            S_INIT_ONE: begin
                we         = 1'b1;
                wa         = REG_ONE;
                sel_in     = SEL_ONE;
                state_next = S_INIT_ACC;
            end
            S_INIT_ACC: begin
                we         = 1'b1;
                wa         = REG_ACC;
                sel_in     = SEL_ONE;
                state_next = S_CHECK;
            end
            S_CHECK: begin
                rea        = 1'b1;
                raa        = REG_CNT;
                state_next = cnt_le1 ? S_DONE : S_MUL;
            end
            S_MUL: begin
                // An overflowing product must not clobber the last valid ACC.
                rea        = 1'b1;
                raa        = REG_ACC;
                reb        = 1'b1;
                rab        = REG_CNT;
                alu_op     = ALU_MUL;
                sel_in     = SEL_ALU;
                wa         = REG_ACC;
                we         = ~alu_ovf;
                state_next = alu_ovf ? S_ERR : S_DEC;
            end
            S_DEC: begin
                rea        = 1'b1;
                raa        = REG_CNT;
                reb        = 1'b1;
                rab        = REG_ONE;
                alu_op     = ALU_SUB;
                sel_in     = SEL_ALU;
                we         = 1'b1;
                wa         = REG_CNT;
                state_next = S_CHECK;
            end
            S_DONE: begin
                done       = 1'b1;
                rea        = 1'b1;
                raa        = REG_ACC;
                state_next = S_IDLE;
            end
            S_ERR: begin
                err        = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Abort overrides every transition and suppresses writes and status pulses.
        if (abort && (state_reg != S_IDLE)) begin
            state_next = S_IDLE;
            we         = 1'b0;
            done       = 1'b0;
            err        = 1'b0;
        end
    end

endmodule

// File: tb/tb_factorial_ctrl.sv
// Directed bench for factorial_ctrl with a small behavioural register file/ALU
// so the status inputs follow the real data.
module tb_factorial_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       cnt_le1;
    logic       alu_ovf;
    logic       we, rea, reb;
    logic [1:0] wa, raa, rab, sel_in;
    logic       alu_op;
    logic       busy, done, err;

    factorial_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cnt_le1 (cnt_le1),
        .alu_ovf (alu_ovf),
        .we      (we),
        .rea     (rea),
        .reb     (reb),
        .wa      (wa),
        .raa     (raa),
        .rab     (rab),
        .sel_in  (sel_in),
        .alu_op  (alu_op),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Datapath model: 4x8 register file, MUL/SUB ALU, data_in mux.
    logic [7:0]  rf [4];
    logic [7:0]  n_in;
    logic [7:0]  rda, rdb, alu_res, din;
    logic [15:0] prod;

    always_comb begin
        rda     = rea ? rf[raa] : 8'd0;
        rdb     = reb ? rf[rab] : 8'd0;
        prod    = 16'(rda) * 16'(rdb);
        alu_res = alu_op ? (rda - rdb) : prod[7:0];
        alu_ovf = !alu_op && reb && (prod[15:8] != 8'd0);
        cnt_le1 = (rda <= 8'd1);
        case (sel_in)
            2'b00:   din = n_in;
            2'b01:   din = 8'd1;
            default: din = alu_res;
        endcase
    end

    always @(posedge clk) if (we) rf[wa] <= din;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    // Per-run observations
    logic [7:0] wr_q[$];
    logic [7:0] mul_q[$];
    int done_n, err_n, mul_n, ovf_we, lat, k_edge;
    logic [7:0] res;

    task automatic run(input logic [7:0] n, input bit repulse);
        wr_q.delete(); mul_q.delete();
        done_n = 0; err_n = 0; mul_n = 0; ovf_we = 0; lat = -1; res = 8'hxx;
        @(negedge clk);
        n_in   = n;
        start  = 1'b1;
        k_edge = edge_cnt + 1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); #1;
            start = (repulse && (c == 5 || c == 9)) ? 1'b1 : 1'b0;
            if (we) wr_q.push_back(din);
            if (rea && reb && alu_op == 1'b0) begin
                mul_n++;
                if (we) mul_q.push_back(din);
                if (alu_ovf && we) ovf_we++;
            end
            if (err) err_n++;
            if (done) begin
                done_n++;
                lat = edge_cnt - k_edge;
                res = rda;
            end
            if (!busy && c > 0) break;
        end
        start = 1'b0;
        if (busy) check("run_timeout_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; n_in = 8'd0;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_we",   32'(we),   0);
        check("rst_done", 32'(done), 0);
        check("rst_err",  32'(err),  0);
        #20 rst_n = 1'b1;

        // n=5 normal run
        run(8'd5, 1'b0);
        check("n5_wr0", 32'(wr_q[0]), 5);
        check("n5_wr1", 32'(wr_q[1]), 1);
        check("n5_wr2", 32'(wr_q[2]), 1);
        check("n5_nmul", mul_q.size(), 4);
        if (mul_q.size() == 4) begin
            check("n5_acc0", 32'(mul_q[0]), 5);
            check("n5_acc1", 32'(mul_q[1]), 20);
            check("n5_acc2", 32'(mul_q[2]), 60);
            check("n5_acc3", 32'(mul_q[3]), 120);
        end
        check("n5_lat",   lat, 16);
        check("n5_res",   32'(res), 120);
        check("n5_done",  done_n, 1);

        // n=0 and n=1: straight to DONE
        run(8'd0, 1'b0);
        check("n0_lat", lat, 4);
        check("n0_mul", mul_n, 0);
        check("n0_res", 32'(res), 1);
        run(8'd1, 1'b0);
        check("n1_lat", lat, 4);
        check("n1_mul", mul_n, 0);
        check("n1_res", 32'(res), 1);

        // n=6 overflows at 120*3
        run(8'd6, 1'b0);
        check("n6_nacc", mul_q.size(), 3);
        if (mul_q.size() == 3) begin
            check("n6_acc0", 32'(mul_q[0]), 6);
            check("n6_acc1", 32'(mul_q[1]), 30);
            check("n6_acc2", 32'(mul_q[2]), 120);
        end
        check("n6_ovf_we", ovf_we, 0);
        check("n6_err",    err_n, 1);
        check("n6_done",   done_n, 0);
        check("n6_accreg", 32'(rf[1]), 120);

        // Start re-pulsed while busy
        run(8'd5, 1'b1);
        check("rep_lat",  lat, 16);
        check("rep_res",  32'(res), 120);
        check("rep_done", done_n, 1);
        @(negedge clk); #1;
        check("rep_idle", 32'(busy), 0);

        // Abort in the second MUL cycle of n=5
        begin
            int m = 0;
            int d = 0;
            int e = 0;
            @(negedge clk);
            n_in = 8'd5; start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int c = 0; c < 60 && m < 2; c++) begin
                @(negedge clk); #1;
                if (rea && reb && alu_op == 1'b0) m++;
                if (done) d++;
                if (err) e++;
            end
            check("ab_mul2", m, 2);
            abort = 1'b1; #1;
            check("ab_we", 32'(we), 0);
            @(negedge clk); #1;
            abort = 1'b0;
            check("ab_idle", 32'(busy), 0);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk); #1;
                if (done) d++;
                if (err) e++;
            end
            check("ab_done", d, 0);
            check("ab_err",  e, 0);
        end

        // Reset dropped mid-DEC, then a fresh run
        begin
            int seen = 0;
            @(negedge clk);
            n_in = 8'd5; start = 1'b1;
            @(negedge clk); start = 1'b0;
            for (int c = 0; c < 60 && seen == 0; c++) begin
                @(negedge clk); #1;
                if (rea && reb && alu_op == 1'b1) seen = 1;
            end
            check("rs_dec", seen, 1);
            #1 rst_n = 1'b0;
            #1;
            check("rs_busy", 32'(busy), 0);
            check("rs_we",   32'(we),   0);
            check("rs_done", 32'(done), 0);
            #10 rst_n = 1'b1;
        end
        run(8'd3, 1'b0);
        check("n3_lat", lat, 10);
        check("n3_res", 32'(res), 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
